sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arb_pkg.sv | 13 +
 rtl/sram_arb_timer.sv | 24 ++
 rtl/sram_arbiter.sv | 120 ++++++++++++
 tb/tb_sram_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared state encoding and default strobe timing for the SRAM arbiter
package sram_arb_pkg;

    typedef enum logic [1:0] {IDLE, RD, WR, RECOV} state_t;

    localparam int RD_CYC_DEF = 4;
    localparam int WR_CYC_DEF = 7;

    function automatic int cnt_width(input int a, input int b);
        return $clog2((a > b ? a : b) + 1);
    endfunction

endpackage

// File: rtl/sram_arb_timer.sv
// sram_arb_timer: loadable down-counter timing the SRAM strobe, done when it reaches zero
module sram_arb_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         done
);

    logic [W-1:0] count;

    assign done = count == '0;

    // load wins over decrement; the count parks at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else if (load) count <= load_val;
        else if (dec && !done) count <= count - 1'b1;
    end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port arbiter onto one async SRAM; SRAM_ARB_RR_EN selects round-robin ties
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int AW     = 19,
    parameter int RD_CYC = RD_CYC_DEF,
    parameter int WR_CYC = WR_CYC_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [7:0]    a_wdata,
    output logic          a_ack,
    output logic [7:0]    a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [7:0]    b_wdata,
    output logic          b_ack,
    output logic [7:0]    b_rdata,
    output logic [AW-1:0] sram_a,
    output logic [7:0]    sram_dq_o,
    output logic          sram_dq_oe,
    input  logic [7:0]    sram_dq_i,
    output logic          sram_we_n,
    output logic          sram_oe_n
);

    localparam int CW = cnt_width(RD_CYC, WR_CYC);

    state_t        state;
    logic          own_b;
    logic          pick_b;
    logic          grant;
    logic          go_we;
    logic          done;
    logic [CW-1:0] ld_val;

`ifdef SRAM_ARB_RR_EN
    logic last_a;
    assign pick_b = b_req && (!a_req || last_a);
`else
    assign pick_b = b_req && !a_req;
`endif

    assign grant  = state == IDLE && (a_req || b_req);
    assign go_we  = pick_b ? b_we : a_we;
    assign ld_val = go_we ? CW'(WR_CYC) : CW'(RD_CYC);

    sram_arb_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (grant),
        .load_val (ld_val),
        .dec      (state == RD || state == WR),
        .done     (done)
    );

    // The cycle after the grant edge is address setup with strobes high; the strobe then
    // stays low until the timer runs out, so sram_a/sram_dq_o lead it by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            own_b      <= 1'b0;
            sram_a     <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            a_ack      <= 1'b0;
            b_ack      <= 1'b0;
            a_rdata    <= '0;
            b_rdata    <= '0;
`ifdef SRAM_ARB_RR_EN
            last_a     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (grant) begin
                    own_b     <= pick_b;
                    sram_a    <= pick_b ? b_addr : a_addr;
                    sram_dq_o <= pick_b ? b_wdata : a_wdata;
                    state     <= go_we ? WR : RD;
`ifdef SRAM_ARB_RR_EN
                    last_a    <= !pick_b;
`endif
                end
                RD: if (done) begin
                    sram_oe_n <= 1'b1;
                    state     <= RECOV;
                    a_ack     <= !own_b;
                    b_ack     <= own_b;
                    if (own_b) b_rdata <= sram_dq_i;
                    else a_rdata <= sram_dq_i;
                end else begin
                    sram_oe_n <= 1'b0;
                end
                WR: if (done) begin
                    sram_we_n  <= 1'b1;
                    sram_dq_oe <= 1'b0;
                    state      <= RECOV;
                    a_ack      <= !own_b;
                    b_ack      <= own_b;
                end else begin
                    sram_we_n  <= 1'b0;
                    sram_dq_oe <= 1'b1;
                end
                RECOV: begin
                    a_ack <= 1'b0;
                    b_ack <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed checks of strobe timing, latency, arbitration and reset
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [18:0] a_addr = '0, b_addr = '0;
    logic [7:0]  a_wdata = '0, b_wdata = '0;
    logic        a_ack, b_ack;
    logic [7:0]  a_rdata, b_rdata;
    logic [18:0] sram_a;
    logic [7:0]  sram_dq_o, sram_dq_i;
    logic        sram_dq_oe, sram_we_n, sram_oe_n;

    int total = 0;
    int bad = 0;

    sram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
        .sram_a(sram_a), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i),
        .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
    );

    always #18 clk = ~clk;

    // small SRAM model: writes land while we_n is low, reads are combinational under oe_n
    logic [7:0] mem [32];
    always @(posedge clk) if (!sram_we_n) mem[sram_a[4:0]] <= sram_dq_o;
    assign sram_dq_i = sram_oe_n ? 8'h00 : mem[sram_a[4:0]];

    // strobe pulse lengths, illegal overlaps, ack pulses and grant order
    int we_run = 0, oe_run = 0, we_len = 0, oe_len = 0, ovl = 0, a_acks = 0, b_acks = 0;
    logic [7:0] glog = '0;
    always @(negedge clk) begin
        if (!sram_we_n) we_run++;
        else if (we_run != 0) begin we_len = we_run; we_run = 0; end
        if (!sram_oe_n) oe_run++;
        else if (oe_run != 0) begin oe_len = oe_run; oe_run = 0; end
        if (!sram_we_n && !sram_oe_n) ovl++;
        if (!sram_oe_n && sram_dq_oe) ovl++;
        if (a_ack) begin a_acks++; glog = {glog[6:0], 1'b0}; end
        if (b_ack) begin b_acks++; glog = {glog[6:0], 1'b1}; end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // one transaction on port p; call just after a posedge. lat = edges from first sample to ack.
    task automatic xact(input bit p, input bit we, input logic [18:0] addr, input logic [7:0] d,
                        output int lat, output logic [7:0] rd);
        logic ack;
        if (p) begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = d; end
        else begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = d; end
        @(posedge clk);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            ack = p ? b_ack : a_ack;
        end while (!ack && lat < 200);
        if (!ack) chk("ack_wait", 32'(ack), 1);
        rd = p ? b_rdata : a_rdata;
        @(posedge clk);
        #1;
        if (p) b_req = 1'b0;
        else a_req = 1'b0;
    endtask

    int lat;
    logic [7:0] rd;
    int acks0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_strobes", 32'({sram_we_n, sram_oe_n, sram_dq_oe, a_ack, b_ack}), 32'b11000);
        chk("rst_rdata", 32'({a_rdata, b_rdata}), 0);
        chk("rst_addr", 32'(sram_a), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        xact(0, 1, 19'h00005, 8'hA5, lat, rd);
        chk("a_wr_lat", 32'(lat), 8);
        chk("a_wr_we_len", 32'(we_len), 7);
        chk("a_wr_addr", 32'(sram_a), 5);
        chk("a_wr_data", 32'(sram_dq_o), 32'hA5);
        chk("a_wr_acks", 32'({a_acks[7:0], b_acks[7:0]}), 32'h0100);

        xact(1, 0, 19'h00005, 8'h00, lat, rd);
        chk("b_rd_lat", 32'(lat), 5);
        chk("b_rd_oe_len", 32'(oe_len), 4);
        chk("b_rd_data", 32'(rd), 32'hA5);
        chk("b_rd_hold", 32'(b_rdata), 32'hA5);

        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    automatic int l;
                    automatic logic [7:0] r;
                    xact(0, 1, 19'(2 * i), 8'(2 * i), l, r);
                end
            end
            begin
                for (int j = 0; j < 8; j++) begin
                    automatic int l;
                    automatic logic [7:0] r;
                    xact(1, 1, 19'(2 * j + 1), 8'(2 * j + 1), l, r);
                end
            end
        join
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    automatic int l;
                    automatic logic [7:0] r;
                    xact(0, 0, 19'(2 * i), 8'h00, l, r);
                    chk("a_readback", 32'(r), 32'(2 * i));
                end
            end
            begin
                for (int j = 0; j < 8; j++) begin
                    automatic int l;
                    automatic logic [7:0] r;
                    xact(1, 0, 19'(2 * j + 1), 8'h00, l, r);
                    chk("b_readback", 32'(r), 32'(2 * j + 1));
                end
            end
        join

        a_req = 1'b1; a_we = 1'b1; a_addr = 19'h00009; a_wdata = 8'h3C;
        acks0 = a_acks;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #5;
        chk("wr_pre_rst", 32'(sram_we_n), 0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_wr", 32'({sram_we_n, sram_dq_oe, a_ack}), 32'b100);
        a_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_no_ack", 32'(a_acks), 32'(acks0));
        xact(0, 1, 19'h0000A, 8'h5A, lat, rd);
        chk("post_rst_wr_lat", 32'(lat), 8);
        xact(0, 0, 19'h0000A, 8'h00, lat, rd);
        chk("post_rst_rd", 32'({lat[7:0], rd}), 32'h055A);

        rst_n = 1'b0;
        #5;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        glog = '0;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    automatic int l;
                    automatic logic [7:0] r;
                    xact(0, 0, 19'(i), 8'h00, l, r);
                end
            end
            begin
                for (int j = 0; j < 4; j++) begin
                    automatic int l;
                    automatic logic [7:0] r;
                    xact(1, 0, 19'(j), 8'h00, l, r);
                end
            end
        join
`ifdef SRAM_ARB_RR_EN
        chk("tie_order", 32'(glog), 32'b01010101);
`else
        chk("tie_order", 32'(glog), 32'b00001111);
`endif
        chk("no_overlap", 32'(ovl), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
